// File: rtl/cpu_sequencer.sv
// Hardwired fetch/execute control sequencer for the simple accumulator CPU datapath.
// Adds run/step control, a memory-read timeout with a sticky error flag, and a retired count.
module cpu_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             clr_err,
  input  logic [1:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             ar_ld_pc,
  output logic             pc_inc,
  output logic             dr_ld_mem,
  output logic             ir_ld,
  output logic             ar_ld_dr,
  output logic             ac_add,
  output logic             ac_and,
  output logic             pc_ld_dr,
  output logic             ac_inc,
  output logic [3:0]       state,
  output logic             busy,
  output logic             instr_done,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Wait-count value seen during the last permitted cycle without mem_ready.
  localparam logic [WaitW-1:0] WaitMax = WaitW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [3:0] {
    StFetch1 = 4'd0,
    StFetch2 = 4'd1,
    StFetch3 = 4'd2,
    StAdd1   = 4'd3,
    StAdd2   = 4'd4,
    StAnd1   = 4'd5,
    StAnd2   = 4'd6,
    StJmp1   = 4'd7,
    StInc1   = 4'd8,
    StIdle   = 4'd9
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic               is_mem, is_last, timeout;

  always_comb begin
    is_mem  = state_q inside {StFetch2, StAdd1, StAnd1};
    is_last = state_q inside {StAdd2, StAnd2, StJmp1, StInc1};
    timeout = (TIMEOUT != 0) && is_mem && !mem_ready && (wait_q == WaitMax);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if ((run || step) && !mem_err_q) state_d = StFetch1;
      StFetch1: state_d = StFetch2;
      StFetch2: begin
        if (mem_ready)    state_d = StFetch3;
        else if (timeout) state_d = StIdle;
      end
      StFetch3: begin
        case (opcode)
          2'b00:   state_d = StAdd1;
          2'b01:   state_d = StAnd1;
          2'b10:   state_d = StJmp1;
          default: state_d = StInc1;
        endcase
      end
      StAdd1: begin
        if (mem_ready)    state_d = StAdd2;
        else if (timeout) state_d = StIdle;
      end
      StAnd1: begin
        if (mem_ready)    state_d = StAnd2;
        else if (timeout) state_d = StIdle;
      end
      StAdd2, StAnd2, StJmp1, StInc1: begin
        state_d = (run && !mem_err_q) ? StFetch1 : StIdle;
      end
      default:  state_d = StIdle;
    endcase

    // Counter restarts whenever a memory state is entered or left.
    wait_d = (is_mem && (state_d == state_q)) ? wait_q + WaitW'(1) : '0;

    if (timeout)      mem_err_d = 1'b1;
    else if (clr_err) mem_err_d = 1'b0;
    else              mem_err_d = mem_err_q;

    instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, is_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    mem_rd     = is_mem;
    dr_ld_mem  = is_mem && mem_ready;
    pc_inc     = (state_q == StFetch2) && mem_ready;
    ar_ld_pc   = (state_q == StFetch1);
    ir_ld      = (state_q == StFetch3);
    ar_ld_dr   = (state_q == StFetch3);
    ac_add     = (state_q == StAdd2);
    ac_and     = (state_q == StAnd2);
    pc_ld_dr   = (state_q == StJmp1);
    ac_inc     = (state_q == StInc1);
    busy       = (state_q != StIdle);
    instr_done = is_last;
    state      = state_q;
    mem_err    = mem_err_q;
    instr_cnt  = instr_cnt_q;
  end

endmodule
